// File: rtl/pic_fetch_pkg.sv
// Shared constants, types and opcode encodings for the PIC fetch stage.
package pic_fetch_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned INSN_W = 14;

  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [INSN_W-1:0] insn_t;

  localparam insn_t      NOP_INSN    = 14'h0000;
  localparam logic [2:0] OPC_GOTO    = 3'b101;
  localparam logic [2:0] OPC_CALL    = 3'b100;
  localparam insn_t      INSN_RETURN = 14'h0008;
  localparam logic [3:0] OPC_RETLW   = 4'b1101;

endpackage

// File: rtl/pic_fetch_unit_if.sv
// ROM bus and execute-stage handshake of the fetch unit.
// PIC_STACK_FLAGS_EN adds the sticky stack overflow/underflow flags.
interface pic_fetch_unit_if;

  pic_fetch_pkg::pc_t   rom_addr_out;
  pic_fetch_pkg::insn_t rom_data_in;
  logic                 stall_in;
  logic                 skip_in;
  pic_fetch_pkg::insn_t ir_out;
  pic_fetch_pkg::pc_t   ir_pc_out;
  logic                 ir_valid_out;
`ifdef PIC_STACK_FLAGS_EN
  logic                 stk_ovf_out;
  logic                 stk_unf_out;
`endif

  modport master (
    output rom_addr_out,
    input  rom_data_in,
    input  stall_in,
    input  skip_in,
    output ir_out,
    output ir_pc_out,
    output ir_valid_out
`ifdef PIC_STACK_FLAGS_EN
    ,
    output stk_ovf_out,
    output stk_unf_out
`endif
  );

  modport slave (
    input  rom_addr_out,
    output rom_data_in,
    output stall_in,
    output skip_in,
    input  ir_out,
    input  ir_pc_out,
    input  ir_valid_out
`ifdef PIC_STACK_FLAGS_EN
    ,
    input  stk_ovf_out,
    input  stk_unf_out
`endif
  );

endinterface

// File: rtl/pic_call_stack.sv
// Circular hardware call stack; overflow overwrites the oldest entry.
// PIC_STACK_FLAGS_EN adds an occupancy counter and sticky ovf/unf flags.
module pic_call_stack
  import pic_fetch_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pc_t  data_in,
  output pc_t  data_out
`ifdef PIC_STACK_FLAGS_EN
  ,
  output logic stk_ovf_out,
  output logic stk_unf_out
`endif
);

  localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PtrW-1:0] sp_q;
  logic [PtrW-1:0] top_idx;
  pc_t             mem_q [STACK_DEPTH];

  assign top_idx  = sp_q - 1'b1;
  assign data_out = mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop) begin
      sp_q <= sp_q - 1'b1;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[sp_q] <= data_in;
    end
  end

`ifdef PIC_STACK_FLAGS_EN
  localparam logic [PtrW:0] OccFull = (PtrW + 1)'(STACK_DEPTH);

  logic [PtrW:0] occ_q;
  logic          ovf_q;
  logic          unf_q;

  // Occupancy saturates at both ends; the flags record the first wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (push) begin
      if (occ_q == OccFull) begin
        ovf_q <= 1'b1;
      end else begin
        occ_q <= occ_q + 1'b1;
      end
    end else if (pop) begin
      if (occ_q == '0) begin
        unf_q <= 1'b1;
      end else begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  assign stk_ovf_out = ovf_q;
  assign stk_unf_out = unf_q;
`endif

endmodule

// File: rtl/pic_fetch_unit.sv
// Instruction fetch stage: PC, IR, local GOTO/CALL/RETURN/RETLW resolution and skip.
// PIC_STACK_FLAGS_EN exposes the call-stack overflow/underflow flags.
module pic_fetch_unit
  import pic_fetch_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  pic_fetch_unit_if.master bus
);

  pc_t   pc_q;
  insn_t ir_q;
  pc_t   ir_pc_q;
  logic  ir_valid_q;

  logic is_goto, is_call, is_ret, is_retlw, is_cf;
  logic push, pop;
  pc_t  stack_top;
  pc_t  cf_target;

  // Decode only real instructions; a bubble never redirects the PC.
  assign is_goto  = ir_valid_q && (ir_q[13:11] == OPC_GOTO);
  assign is_call  = ir_valid_q && (ir_q[13:11] == OPC_CALL);
  assign is_ret   = ir_valid_q && (ir_q == INSN_RETURN);
  assign is_retlw = ir_valid_q && (ir_q[13:10] == OPC_RETLW);
  assign is_cf    = is_goto | is_call | is_ret | is_retlw;

  assign push = is_call && !bus.stall_in && !rst;
  assign pop  = (is_ret || is_retlw) && !bus.stall_in && !rst;

  always_comb begin
    cf_target = ir_q[ADDR_W-1:0];
    if (is_ret || is_retlw) begin
      cf_target = stack_top;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      ir_q       <= NOP_INSN;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else if (!bus.stall_in) begin
      ir_pc_q <= pc_q;
      if (is_cf) begin
        // The word fetched alongside a taken branch is flushed.
        pc_q       <= cf_target;
        ir_q       <= NOP_INSN;
        ir_valid_q <= 1'b0;
      end else begin
        pc_q <= pc_q + 1'b1;
        if (bus.skip_in && ir_valid_q) begin
          ir_q       <= NOP_INSN;
          ir_valid_q <= 1'b0;
        end else begin
          ir_q       <= bus.rom_data_in;
          ir_valid_q <= 1'b1;
        end
      end
    end
  end

  pic_call_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .data_in     (pc_q),
    .data_out    (stack_top)
`ifdef PIC_STACK_FLAGS_EN
    ,
    .stk_ovf_out (bus.stk_ovf_out),
    .stk_unf_out (bus.stk_unf_out)
`endif
  );

  assign bus.rom_addr_out = pc_q;
  assign bus.ir_out       = ir_q;
  assign bus.ir_pc_out    = ir_pc_q;
  assign bus.ir_valid_out = ir_valid_q;

endmodule
